// File: rtl/robm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : robm_pkg
// Description : Shared constants and types for the robm input conditioning
//               stage: channel count, debounce default, and the mapping of
//               raw_in bit positions onto the x1..x12 controller inputs.
// Revision    : 1.0 - initial release
// ============================================================================
package robm_pkg;

    // Number of raw sensor / limit-switch channels feeding robm.
    localparam int ROBM_NX          = 12;

    // Default number of consecutive differing samples needed to accept a level.
    localparam int ROBM_DEB_DEFAULT = 4;

    // Bit i-1 of the conditioned vector is x_i. Declaring the packed struct
    // MSB-first places x1 at bit 0 and x12 at bit 11.
    typedef struct packed {
        logic x12;
        logic x11;
        logic x10;
        logic x9;
        logic x8;
        logic x7;
        logic x6;
        logic x5;
        logic x4;
        logic x3;
        logic x2;
        logic x1;
    } robm_x_t;

endpackage : robm_pkg
`default_nettype wire

// File: rtl/robm_deb_ch.sv
`default_nettype none
// ============================================================================
// Module      : robm_deb_ch
// Description : One input channel of the robm conditioning stage: two-flop
//               synchronizer, consecutive-sample debounce counter and the
//               debounced level flop. Exposes next-state values so the top
//               level can register its chg/stable flags in the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module robm_deb_ch
    import robm_pkg::*;
#(
    parameter int   DEB_CYCLES = ROBM_DEB_DEFAULT,
    parameter logic RST_BIT    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb,
    output logic deb_next,
    output logic s2_next,
    output logic cnt_zero,
    output logic glitch
);

    localparam int            CW         = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    logic          r_s1;
    logic          r_s2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;

    logic          w_deb_next;
    logic [CW-1:0] w_cnt_next;

    // Metastability guard: plain flop pair with nothing between the stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= RST_BIT;
            r_s2 <= RST_BIT;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
        end
    end

    // Next-state decode: a matching sample zeroes the count (no partial
    // credit), the last differing sample commits the new level.
    always_comb begin
        w_deb_next = r_deb;
        w_cnt_next = '0;
        if (r_s2 != r_deb) begin
            if (r_cnt == c_cnt_last) begin
                w_deb_next = r_s2;
            end else begin
                w_cnt_next = r_cnt + c_cnt_one;
            end
        end
    end

    // Debounce state: counter and accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb <= RST_BIT;
            r_cnt <= '0;
        end else begin
            r_deb <= w_deb_next;
            r_cnt <= w_cnt_next;
        end
    end

    assign deb      = r_deb;
    assign deb_next = w_deb_next;
    assign s2_next  = r_s1;
    assign cnt_zero = (w_cnt_next == '0);
    // A count in progress that meets a matching sample is a rejected glitch.
    assign glitch   = (r_cnt != '0) && (r_s2 == r_deb);

endmodule : robm_deb_ch
`default_nettype wire

// File: rtl/robm_in_cond.sv
`default_nettype none
// ============================================================================
// Module      : robm_in_cond
// Description : Input conditioning for the robm controller FSM. Synchronizes
//               and debounces the 12 raw sensor lines into x1..x12, and
//               provides a change pulse (chg) and a quiescence flag (stable).
//               Optional build macro ROBM_IN_GLITCH_CNT_EN adds an 8-bit
//               saturating count of rejected glitch events on glitch_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module robm_in_cond
    import robm_pkg::*;
#(
    parameter int                 DEB_CYCLES = ROBM_DEB_DEFAULT,
    parameter logic [ROBM_NX-1:0] RST_VAL    = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ROBM_NX-1:0] raw_in,
    output logic               x1,
    output logic               x2,
    output logic               x3,
    output logic               x4,
    output logic               x5,
    output logic               x6,
    output logic               x7,
    output logic               x8,
    output logic               x9,
    output logic               x10,
    output logic               x11,
    output logic               x12,
    output logic               chg,
    output logic               stable
`ifdef ROBM_IN_GLITCH_CNT_EN
    ,
    output logic [7:0]         glitch_cnt
`endif
);

    logic [ROBM_NX-1:0] w_deb;
    logic [ROBM_NX-1:0] w_deb_next;
    logic [ROBM_NX-1:0] w_s2_next;
    logic [ROBM_NX-1:0] w_cnt_zero;
    logic [ROBM_NX-1:0] w_glitch;
    robm_x_t            w_x;

    logic               r_chg;
    logic               r_stable;

    // Independent per-channel conditioning; no priority between channels.
    for (genvar gi = 0; gi < ROBM_NX; gi++) begin : g_ch
        robm_deb_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .RST_BIT    (RST_VAL[gi])
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .raw      (raw_in[gi]),
            .deb      (w_deb[gi]),
            .deb_next (w_deb_next[gi]),
            .s2_next  (w_s2_next[gi]),
            .cnt_zero (w_cnt_zero[gi]),
            .glitch   (w_glitch[gi])
        );
    end

    // Status flags registered from next-state values so they line up with
    // the debounced outputs they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chg    <= 1'b0;
            r_stable <= 1'b0;
        end else begin
            r_chg    <= |(w_deb_next ^ w_deb);
            r_stable <= (&w_cnt_zero) && (w_s2_next == w_deb_next);
        end
    end

    assign chg    = r_chg;
    assign stable = r_stable;

`ifdef ROBM_IN_GLITCH_CNT_EN
    logic [7:0] r_glitch_cnt;

    // One event per edge regardless of how many channels rejected a glitch;
    // holds at 255 instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_glitch_cnt <= 8'h00;
        end else if ((|w_glitch) && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'h01;
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`else
    logic w_unused_glitch;
    assign w_unused_glitch = |w_glitch;
`endif

    // Fan-out of the debounced vector onto the individual x ports.
    assign w_x = robm_x_t'(w_deb);
    assign x1  = w_x.x1;
    assign x2  = w_x.x2;
    assign x3  = w_x.x3;
    assign x4  = w_x.x4;
    assign x5  = w_x.x5;
    assign x6  = w_x.x6;
    assign x7  = w_x.x7;
    assign x8  = w_x.x8;
    assign x9  = w_x.x9;
    assign x10 = w_x.x10;
    assign x11 = w_x.x11;
    assign x12 = w_x.x12;

endmodule : robm_in_cond
`default_nettype wire

// File: tb/tb_robm_in_cond.sv
`default_nettype none
// ============================================================================
// Module      : tb_robm_in_cond
// Description : Directed self-checking bench for robm_in_cond. Instance u_dut
//               uses the default debounce depth and reset level; instance
//               u_dut1 uses DEB_CYCLES = 1 and a non-zero reset level.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_robm_in_cond;

    logic        clk;
    logic        rst;
    logic [11:0] raw_in;
    logic [11:0] raw1;
    logic [11:0] xa;
    logic [11:0] xb;
    logic        chg;
    logic        stable;
    logic        chg1;
    logic        stable1;
`ifdef ROBM_IN_GLITCH_CNT_EN
    logic [7:0]  gcnt;
    logic [7:0]  gcnt1;
`endif

    int n_cmp;
    int n_fail;

    robm_in_cond u_dut (
        .clk    (clk),
        .rst    (rst),
        .raw_in (raw_in),
        .x1     (xa[0]),
        .x2     (xa[1]),
        .x3     (xa[2]),
        .x4     (xa[3]),
        .x5     (xa[4]),
        .x6     (xa[5]),
        .x7     (xa[6]),
        .x8     (xa[7]),
        .x9     (xa[8]),
        .x10    (xa[9]),
        .x11    (xa[10]),
        .x12    (xa[11]),
        .chg    (chg),
        .stable (stable)
`ifdef ROBM_IN_GLITCH_CNT_EN
        ,
        .glitch_cnt (gcnt)
`endif
    );

    robm_in_cond #(
        .DEB_CYCLES (1),
        .RST_VAL    (12'h0A5)
    ) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .raw_in (raw1),
        .x1     (xb[0]),
        .x2     (xb[1]),
        .x3     (xb[2]),
        .x4     (xb[3]),
        .x5     (xb[4]),
        .x6     (xb[5]),
        .x7     (xb[6]),
        .x8     (xb[7]),
        .x9     (xb[8]),
        .x10    (xb[9]),
        .x11    (xb[10]),
        .x12    (xb[11]),
        .chg    (chg1),
        .stable (stable1)
`ifdef ROBM_IN_GLITCH_CNT_EN
        ,
        .glitch_cnt (gcnt1)
`endif
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; all driving and sampling happens 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (xa !== 12'h000) begin n_fail++; $display("FAIL reset_x actual=%h required=%h", xa, 12'h000); end
        n_cmp++;
        if (xb !== 12'h0A5) begin n_fail++; $display("FAIL reset_x_rstval actual=%h required=%h", xb, 12'h0A5); end
        n_cmp++;
        if (chg !== 1'b0) begin n_fail++; $display("FAIL reset_chg actual=%b required=0", chg); end
        n_cmp++;
        if (stable !== 1'b0) begin n_fail++; $display("FAIL reset_stable actual=%b required=0", stable); end
`ifdef ROBM_IN_GLITCH_CNT_EN
        n_cmp++;
        if (gcnt !== 8'd0) begin n_fail++; $display("FAIL reset_glitch_cnt actual=%0d required=0", gcnt); end
`endif
        rst = 1'b0;
        tick();
        n_cmp++;
        if (stable !== 1'b1) begin n_fail++; $display("FAIL stable_after_release actual=%b required=1", stable); end
        n_cmp++;
        if (stable1 !== 1'b1) begin n_fail++; $display("FAIL stable1_after_release actual=%b required=1", stable1); end
    endtask

    task automatic test_clean_rise();
        raw_in[0] = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            tick();
            n_cmp++;
            if (xa[0] !== (e >= 5)) begin n_fail++; $display("FAIL rise_x1 edge=%0d actual=%b required=%b", e, xa[0], (e >= 5)); end
            n_cmp++;
            if (chg !== (e == 5)) begin n_fail++; $display("FAIL rise_chg edge=%0d actual=%b required=%b", e, chg, (e == 5)); end
            n_cmp++;
            if (stable !== (e == 0 || e >= 5)) begin n_fail++; $display("FAIL rise_stable edge=%0d actual=%b required=%b", e, stable, (e == 0 || e >= 5)); end
        end
    endtask

    task automatic test_glitch();
`ifdef ROBM_IN_GLITCH_CNT_EN
        logic [7:0] g0;
        g0 = gcnt;
`endif
        raw_in[4] = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            if (e == 3) raw_in[4] = 1'b0;
            tick();
            n_cmp++;
            if (xa[4] !== 1'b0) begin n_fail++; $display("FAIL glitch_x5 edge=%0d actual=%b required=0", e, xa[4]); end
            n_cmp++;
            if (chg !== 1'b0) begin n_fail++; $display("FAIL glitch_chg edge=%0d actual=%b required=0", e, chg); end
        end
`ifdef ROBM_IN_GLITCH_CNT_EN
        n_cmp++;
        if (gcnt !== g0 + 8'd1) begin n_fail++; $display("FAIL glitch_cnt actual=%0d required=%0d", gcnt, g0 + 8'd1); end
`endif
    endtask

    task automatic test_bounce();
        logic [6:0] pat;
        pat = 7'b1111011;  // per-cycle values 1,1,0,1,1,1,1 from bit 0 upward
        for (int e = 0; e <= 10; e++) begin
            if (e < 7) raw_in[11] = pat[e];
            tick();
            n_cmp++;
            if (xa[11] !== (e >= 8)) begin n_fail++; $display("FAIL bounce_x12 edge=%0d actual=%b required=%b", e, xa[11], (e >= 8)); end
            n_cmp++;
            if (chg !== (e == 8)) begin n_fail++; $display("FAIL bounce_chg edge=%0d actual=%b required=%b", e, chg, (e == 8)); end
        end
    endtask

    task automatic test_simultaneous();
`ifdef ROBM_IN_GLITCH_CNT_EN
        logic [7:0] g0;
`endif
        raw_in = 12'h000;
        repeat (10) tick();
        n_cmp++;
        if (xa !== 12'h000) begin n_fail++; $display("FAIL simul_settle actual=%h required=%h", xa, 12'h000); end
`ifdef ROBM_IN_GLITCH_CNT_EN
        g0 = gcnt;
`endif
        raw_in = 12'hFFF;
        for (int e = 0; e <= 7; e++) begin
            tick();
            n_cmp++;
            if (xa !== ((e >= 5) ? 12'hFFF : 12'h000)) begin n_fail++; $display("FAIL simul_x edge=%0d actual=%h required=%h", e, xa, ((e >= 5) ? 12'hFFF : 12'h000)); end
            n_cmp++;
            if (chg !== (e == 5)) begin n_fail++; $display("FAIL simul_chg edge=%0d actual=%b required=%b", e, chg, (e == 5)); end
        end
`ifdef ROBM_IN_GLITCH_CNT_EN
        n_cmp++;
        if (gcnt !== g0) begin n_fail++; $display("FAIL simul_glitch_cnt actual=%0d required=%0d", gcnt, g0); end
`endif
    endtask

    task automatic test_reset_mid();
        raw_in = 12'h000;
        repeat (10) tick();
        raw_in[2] = 1'b1;
        repeat (4) tick();   // edges 0..3: two compares done, count at 2
        rst = 1'b1;
        tick();
        n_cmp++;
        if (xa !== 12'h000) begin n_fail++; $display("FAIL rstmid_x actual=%h required=%h", xa, 12'h000); end
        n_cmp++;
        if (xb !== 12'h0A5) begin n_fail++; $display("FAIL rstmid_x_rstval actual=%h required=%h", xb, 12'h0A5); end
        n_cmp++;
        if (chg !== 1'b0) begin n_fail++; $display("FAIL rstmid_chg actual=%b required=0", chg); end
        n_cmp++;
        if (stable !== 1'b0) begin n_fail++; $display("FAIL rstmid_stable actual=%b required=0", stable); end
        rst = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            tick();
            n_cmp++;
            if (xa[2] !== (e >= 5)) begin n_fail++; $display("FAIL rstmid_x3 edge=%0d actual=%b required=%b", e, xa[2], (e >= 5)); end
            n_cmp++;
            if (chg !== (e == 5)) begin n_fail++; $display("FAIL rstmid_chg_after edge=%0d actual=%b required=%b", e, chg, (e == 5)); end
        end
    endtask

    task automatic test_deb1();
        logic exp_x8;
        for (int k = 0; k < 16; k++) begin
            raw1[7] = ((k >> 1) & 1) != 0;
            tick();
            // Before the toggling began the line had been steady at 1.
            exp_x8 = (k < 2) ? 1'b1 : ((((k - 2) >> 1) & 1) != 0);
            n_cmp++;
            if (xb[7] !== exp_x8) begin n_fail++; $display("FAIL deb1_x8 edge=%0d actual=%b required=%b", k, xb[7], exp_x8); end
        end
    endtask

    initial begin
        clk    = 1'b0;
        rst    = 1'b1;
        raw_in = 12'h000;
        raw1   = 12'h0A5;
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_clean_rise();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_deb1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_robm_in_cond
`default_nettype wire

// File: doc/robm_in_cond.md
# robm_in_cond

Input conditioning stage for the `robm` robot-controller FSM. Takes the 12 raw, asynchronous sensor/limit-switch lines and produces the clean, glitch-free `x1`–`x12` levels that `robm` samples. Each line passes through a two-flop synchronizer and a per-channel debounce counter. Outputs are registered on the rising edge, so they are settled well before `robm`'s falling-edge state update.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: consecutive differing samples required to accept a new level; legal range 1–255.
- `RST_VAL`, default 12'h000: reset level of the synchronizers and of the debounced outputs. Bit i-1 corresponds to x_i.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `raw_in` in 12: asynchronous raw inputs; bit i-1 feeds x_i.
- `x1` … `x12` out 1 each: debounced levels, registered.
- `chg` out 1: one-cycle pulse; high in the cycle after any x bit changed.
- `stable` out 1: high when no channel has a pending count and all synchronized inputs equal the debounced outputs.
- `glitch_cnt` out 8: present only when `ROBM_IN_GLITCH_CNT_EN` is defined; see Configuration.

## Operation
- Sync chain per channel: `s1 <= raw_in[i]`, then `s2 <= s1`. No logic sits between the two flops.
- Per-channel counter `cnt`, width `$clog2(DEB_CYCLES+1)`. On each edge the channel takes exactly one of these actions:
  - `s2 == deb`: `cnt <= 0`.
  - `s2 != deb` and `cnt == DEB_CYCLES-1`: `deb <= s2`, `cnt <= 0`.
  - `s2 != deb` otherwise: `cnt <= cnt+1`.
- A bounce back to the old level mid-count zeroes `cnt`. There is no partial credit; a later change restarts the count from 1.
- A pulse shorter than `DEB_CYCLES` compare cycles never reaches x.
- `DEB_CYCLES == 1`: x follows `s2` one edge later, with no filtering.
- `chg <= |(deb_next ^ deb)`. It is asserted even when several channels update on the same edge.
- `stable <= (all cnt_next == 0) && (s2_next == deb_next)` across all channels.
- Channels are fully independent. Simultaneous transitions on several lines are handled per channel, with no priority between them.

## Timing
- Reset values: `s1`, `s2`, and x1–x12 take the matching bit of `RST_VAL`. All `cnt` = 0. `chg` = 0. `stable` = 0. `glitch_cnt` = 0.
- Reset asserted mid-count aborts every pending change on that edge. The outputs return to `RST_VAL` regardless of their current value.
- Edge numbering: edge 0 is the first edge that samples a new raw level into `s1`. The raw level must be held through the whole sequence.
  - `s2` updates at edge 1.
  - Compares occur at edges 2 … DEB_CYCLES+1.
  - x updates at edge DEB_CYCLES+1; this is 5 edges for the default.
  - `chg` is high during the cycle following edge DEB_CYCLES+1.
- `stable` first goes high one edge after `rst` deasserts, provided `raw_in == RST_VAL`.
- Outputs change only on rising edges. `robm` samples on the falling edge, so it sees values from the preceding rising edge.

## Configuration
- `ROBM_IN_GLITCH_CNT_EN`:
  - When defined: adds the `glitch_cnt` port and an 8-bit counter. The counter increments by 1 on each edge where any channel has `cnt != 0` and `s2 == deb` (a rejected glitch).
    - Several channels rejecting glitches on the same edge count as a single event.
    - The counter saturates at 255.
    - It is cleared only by `rst`.
  - When undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `robm_pkg`:
  - `ROBM_NX = 12`, the number of input channels.
  - `ROBM_DEB_DEFAULT = 4`.
  - The bit-to-x_i index mapping.
- One sub-module, `robm_deb_ch`, generated `ROBM_NX` times:
  - Contents: sync pair, counter, and debounced flop for one channel.
  - Outputs: `deb`, `deb_next`, `cnt_zero`, and `glitch` strobe.
- The top level holds the `chg`/`stable` aggregation, the optional glitch counter, and the fan-out to the x1–x12 ports.

## Test plan
- **Reset and clean rise:** `rst` for 2 cycles, `RST_VAL` = 0, then `raw_in[0]` set to 1 and held. Required: x1 = 0 through edge 4 and 1 from edge 5; `chg` high for exactly one cycle; `stable` = 0 during edges 1–4 and 1 after edge 5.
- **Rejected glitch:** `raw_in[4]` high for 3 cycles, then low. Required: x5 stays 0, `chg` never asserts, and (with the macro defined) `glitch_cnt` = 1.
- **Bounce and restart:** `raw_in[11]` pattern 1,1,0,1,1,1,1 (one value per cycle). Required: x12 rises exactly 5 edges after the last 0→1 transition.
- **Simultaneous changes:** `raw_in` 12'h000 → 12'hFFF in one cycle. Required: all of x1–x12 rise on the same edge, `chg` is a single one-cycle pulse, and `glitch_cnt` is unchanged.
- **Reset mid-count:** start a change on `raw_in[2]`, then assert `rst` at compare count 2. Required: x3 = `RST_VAL` bit 2, and after release the full `DEB_CYCLES`+1 latency applies again.
- **`DEB_CYCLES = 1` build:** toggle `raw_in[7]` every 2 cycles. Required: x8 follows `raw_in[7]` delayed by 2 edges, with every toggle passed through.
